// File: rtl/cpu_clock_ctrl_if.sv
// Run-control bus between the operator/CPU side and cpu_clock_ctrl.
// Breakpoint signals exist only when CPU_CLOCK_CTRL_BRKPT_EN is defined.
interface cpu_clock_ctrl_if #(
    parameter int PC_W = 8
);
    logic [1:0]      mode;
    logic            step_btn;
    logic            cpu_halt;
    logic            cpu_tick;
    logic            running;
    logic [15:0]     tick_count;
`ifdef CPU_CLOCK_CTRL_BRKPT_EN
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] bp_addr;
    logic            bp_valid;
    logic            bp_hit;

    modport master (
        output mode, step_btn, cpu_halt, pc, bp_addr, bp_valid,
        input  cpu_tick, running, tick_count, bp_hit
    );
    modport slave (
        input  mode, step_btn, cpu_halt, pc, bp_addr, bp_valid,
        output cpu_tick, running, tick_count, bp_hit
    );
`else
    modport master (
        output mode, step_btn, cpu_halt,
        input  cpu_tick, running, tick_count
    );
    modport slave (
        input  mode, step_btn, cpu_halt,
        output cpu_tick, running, tick_count
    );
`endif
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU run control: halt / debounced single-step / slow / fast clock-enable generation.
// Optional PC breakpoint stop is enabled by defining CPU_CLOCK_CTRL_BRKPT_EN.
module cpu_clock_ctrl #(
    parameter int FAST_DIV   = 1,
    parameter int SLOW_DIV   = 12000000,
    parameter int DEB_CYCLES = 120000,
    parameter int PC_W       = 8
) (
    input logic             clock_in,
    input logic             nReset,
    cpu_clock_ctrl_if.slave bus
);
    // Following states share the encoding of the mode switches they track.
    localparam logic [2:0] ST_HALT    = 3'd0;
    localparam logic [2:0] ST_STEP    = 3'd1;
    localparam logic [2:0] ST_SLOW    = 3'd2;
    localparam logic [2:0] ST_FAST    = 3'd3;
    localparam logic [2:0] ST_STOPPED = 3'd4;

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DIV_W   = $clog2(MAX_DIV);
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DIV_W-1:0] SLOW_TERM = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_TERM = DIV_W'(FAST_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TERM  = DEB_W'(DEB_CYCLES - 1);

    generate
        if (FAST_DIV < 1 || SLOW_DIV < 2 || DEB_CYCLES < 1 || PC_W < 1) begin : g_bad_param
            $error("cpu_clock_ctrl: illegal parameter value");
        end
    endgenerate

    logic [2:0]       sync_s1_q, sync_s2_q;
    logic [1:0]       mode_last_q;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_q, deb_d;
    logic             step_req_q, step_req_d;
    logic [15:0]      tick_count_q, tick_count_d;

    logic [1:0]       mode_sync;
    logic             btn_sync;
    logic             mode_chg;
    logic             in_run;
    logic [DIV_W-1:0] div_term;
    logic             would_tick;
    logic             bp_match;
    logic             stop_req;
    logic             tick;

    assign mode_sync = sync_s2_q[1:0];
    assign btn_sync  = sync_s2_q[2];
    assign mode_chg  = (mode_sync != mode_last_q);
    assign in_run    = (state_q == ST_SLOW) || (state_q == ST_FAST);
    assign div_term  = (state_q == ST_SLOW) ? SLOW_TERM : FAST_TERM;

    // A mode change in the terminal-count cycle takes priority over the tick.
    assign would_tick = in_run && !mode_chg && (div_q == div_term);

`ifdef CPU_CLOCK_CTRL_BRKPT_EN
    assign bp_match = bus.bp_valid && (bus.pc == bus.bp_addr);
`else
    assign bp_match = 1'b0;
`endif

    assign stop_req = would_tick && (bus.cpu_halt || bp_match);
    assign tick     = (would_tick && !stop_req) || ((state_q == ST_STEP) && step_req_q);

    assign bus.cpu_tick   = tick;
    assign bus.running    = in_run;
    assign bus.tick_count = tick_count_q;

    always_comb begin
        state_d = state_q;
        if (mode_chg) begin
            state_d = {1'b0, mode_sync};
        end else if (stop_req) begin
            state_d = ST_STOPPED;
        end

        div_d = '0;
        if (in_run && !mode_chg && (div_q != div_term)) begin
            div_d = div_q + DIV_W'(1);
        end

        tick_count_d = tick_count_q + 16'(tick);

        // Level must differ from the accepted one for DEB_CYCLES consecutive cycles.
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        step_req_d = 1'b0;
        if (btn_sync != deb_q) begin
            if (deb_cnt_q == DEB_TERM) begin
                deb_d      = btn_sync;
                step_req_d = btn_sync;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            sync_s1_q    <= '0;
            sync_s2_q    <= '0;
            mode_last_q  <= '0;
            state_q      <= ST_HALT;
            div_q        <= '0;
            deb_cnt_q    <= '0;
            deb_q        <= 1'b0;
            step_req_q   <= 1'b0;
            tick_count_q <= '0;
        end else begin
            sync_s1_q    <= {bus.step_btn, bus.mode};
            sync_s2_q    <= sync_s1_q;
            mode_last_q  <= mode_sync;
            state_q      <= state_d;
            div_q        <= div_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_q        <= deb_d;
            step_req_q   <= step_req_d;
            tick_count_q <= tick_count_d;
        end
    end

`ifdef CPU_CLOCK_CTRL_BRKPT_EN
    logic bp_hit_q, bp_hit_d;

    always_comb begin
        bp_hit_d = bp_hit_q;
        if (mode_chg) begin
            bp_hit_d = 1'b0;
        end else if (stop_req && bp_match) begin
            bp_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bus.bp_hit = bp_hit_q;
`endif
endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run-control block for the 8-bit CPU. It turns the 12 MHz board clock into a single-cycle CPU clock-enable, `cpu_tick`, under one of four operator-selected modes: halt, single-step (debounced push-button), slow run (1 Hz default) and fast run. It stops on the CPU's own HLT indication and, when configured, on a PC breakpoint. All CPU registers run on `clock_in` and advance only when `cpu_tick` is high.

## Interface
- `FAST_DIV`, default 1: clock_in cycles per tick in fast mode (1 = every cycle); legal range ≥1.
- `SLOW_DIV`, default 12000000: clock_in cycles per tick in slow mode; legal range ≥2.
- `DEB_CYCLES`, default 120000: cycles of stable button level required for acceptance (10 ms at 12 MHz).
- `PC_W`, default 8: program counter width.

Ports:
- `clock_in`  in  1  system clock, 12 MHz.
- `nReset`  in  1  reset; asynchronous, active-low.
- `mode`  in  2  asynchronous switches: 00 halt, 01 step, 10 slow, 11 fast.
- `step_btn`  in  1  raw push-button, active-high, asynchronous, bouncing.
- `cpu_halt`  in  1  level from the CPU, high while the CPU is executing HLT.
- `cpu_tick`  out  1  one-cycle clock-enable to the CPU.
- `running`  out  1  high in the SLOW_RUN and FAST_RUN states.
- `tick_count`  out  16  count of issued ticks.
- `pc`  in  PC_W  current CPU PC. Present only with the macro.
- `bp_addr`  in  PC_W  breakpoint address. Present only with the macro.
- `bp_valid`  in  1  breakpoint armed. Present only with the macro.
- `bp_hit`  out  1  sticky breakpoint flag. Present only with the macro.

## Operation
- `mode` and `step_btn` each pass through a 2-flop synchronizer (reset value 0).
- Debouncer:
  - A counter restarts whenever the synchronized button differs from the debounced level.
  - When the counter reaches DEB_CYCLES-1 with the level unchanged, the debounced level updates.
  - A 0→1 debounced edge produces one internal `step_req` pulse.
- FSM states: HALT, STEP, SLOW_RUN, FAST_RUN, STOPPED.
  - In HALT, STEP, SLOW_RUN and FAST_RUN, the state follows the synchronized mode (00/01/10/11).
  - STEP: each `step_req` gives one `cpu_tick`. `step_req` is ignored in every other state. `cpu_halt` does not block a step.
  - SLOW_RUN/FAST_RUN: the divider counts 0..DIV-1. A tick is issued in the cycle the count equals DIV-1, then the count wraps to 0.
  - From SLOW_RUN or FAST_RUN: `cpu_halt` high in the would-be tick cycle suppresses that tick and moves the FSM to STOPPED.
  - STOPPED: no ticks. Exit only on a change of the synchronized mode, to the new mode's state.
- Any change of the synchronized mode clears the divider to 0.
- `tick_count` increments on every issued tick and wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: `cpu_tick`=0, `running`=0, `tick_count`=0, `bp_hit`=0. State HALT, divider 0, debounced level 0.
- Mode change: the new state is registered 3 clock_in cycles after the `mode` pins change.
- First tick after entering a run state: DIV cycles after entry, counting the entry cycle as 1.
- Step: `cpu_tick` is high in the cycle after the debounced rising edge, for exactly 1 cycle.
  - Holding the button gives one tick.
  - A release shorter than DEB_CYCLES gives no new tick.
- Simultaneous mode change and divider terminal count: the mode change wins and no tick is issued.
- `nReset` asserted mid-operation: all outputs go to reset values immediately. No partial tick is issued.

## Configuration
- Macro: `CPU_CLOCK_CTRL_BRKPT_EN`.
- When defined:
  - The breakpoint ports exist.
  - In SLOW_RUN/FAST_RUN, a would-be tick cycle with `bp_valid`=1 and `pc`==`bp_addr` suppresses the tick, sets `bp_hit` and moves the FSM to STOPPED.
  - `bp_hit` clears on any synchronized mode change.
  - The breakpoint is ignored in STEP.
- When undefined: the breakpoint ports are absent, and behaviour is otherwise identical.

## Test plan
All scenarios use SLOW_DIV=10, FAST_DIV=1, DEB_CYCLES=4.
- Reset, then mode=10 → first tick 13 cycles after the pin change, then one tick every 10 cycles; `running`=1; `tick_count` is 3 after 3 ticks.
- Mode=11 → `cpu_tick` high every cycle. Assert `cpu_halt` → the tick stops that same cycle and the FSM is STOPPED. Toggle mode to 10 → ticks resume.
- Mode=01; button high for 20 cycles with 1-cycle glitches in the first 3 → exactly one 1-cycle tick. Two clean presses → `tick_count`=2.
- Mode=01; button pressed while mode switches to 00 → no tick after HALT is entered.
- `nReset` pulsed during fast run → `cpu_tick`, `running` and `tick_count` are 0 the same cycle; the state is HALT after release until mode resyncs.
- With the macro: bp_addr=0x05, bp_valid=1, `pc` stepping 0..; fast run → no tick when `pc`=0x05, `bp_hit`=1, STOPPED; a mode change clears `bp_hit`.
